// File: rtl/ldpc_3gpp_enc_p1_obuf.sv
// Ping-pong output buffer behind the p1 (invPsi) stage of the 3GPP LDPC encoder.
// Two RAM banks fill from the p1 writer and drain over valid/ready via a 2-entry skid FIFO.
module ldpc_3gpp_enc_p1_obuf #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              ival,
    input  logic              isof,
    input  logic              ieof,
    input  logic [pDAT_W-1:0] idat,
    output logic              obusy,
    output logic              oerr,
    output logic              oval,
    input  logic              iready,
    output logic              osof,
    output logic              oeof,
    output logic [pDAT_W-1:0] odat
);
    localparam int DEPTH = 2**pADDR_W;
    localparam logic [pADDR_W:0] ONE = (pADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, FILL, FULL} bst_t;

    logic [pDAT_W-1:0]  mem [2*DEPTH];
    bst_t               bst [2];
    bst_t               bst_n [2];
    logic [pADDR_W:0]   len [2];
    logic [pADDR_W:0]   len_n [2];
    logic               wbank, wbank_n;
    logic [pADDR_W:0]   waddr, waddr_n;
    logic               we;
    logic [pADDR_W-1:0] wa;
    logic               err_n;

    logic               ibank;
    logic [pADDR_W:0]   iaddr;
    logic [1:0]         issued;
    logic               rbank;

    logic [pDAT_W-1:0]  fdat [2];
    logic [1:0]         fsof, feof;
    logic               fwp, frp;
    logic [1:0]         fcnt;
    logic               pop, rel, issue, last;

    assign oval  = (fcnt != 2'd0);
    assign odat  = fdat[frp];
    assign osof  = fsof[frp];
    assign oeof  = feof[frp];
    assign pop   = iclkena & oval & iready;
    assign rel   = pop & feof[frp];
    assign last  = (iaddr == len[ibank] - ONE);
    // a pop in the same cycle frees a slot, keeping the stream bubble-free
    assign issue = iclkena & (bst[ibank] == FULL) & ~issued[ibank]
                 & ((fcnt != 2'd2) | pop);

    always_comb begin
        bst_n   = bst;
        len_n   = len;
        wbank_n = wbank;
        waddr_n = waddr;
        we      = 1'b0;
        wa      = '0;
        err_n   = 1'b0;
        if (iclkena && ival) begin
            unique case (bst[wbank])
                FULL: err_n = 1'b1;
                IDLE, FILL: begin
                    if (isof) begin
                        we             = 1'b1;
                        wa             = '0;
                        waddr_n        = ONE;
                        bst_n[wbank]   = FILL;
                    end else if (bst[wbank] == FILL) begin
                        if (waddr[pADDR_W]) begin
                            err_n = 1'b1;
                        end else begin
                            we      = 1'b1;
                            wa      = waddr[pADDR_W-1:0];
                            waddr_n = waddr + ONE;
                        end
                    end
                    // waddr_n saturates at capacity, so it is the frame length
                    if (ieof && (isof || bst[wbank] == FILL)) begin
                        len_n[wbank] = waddr_n;
                        bst_n[wbank] = FULL;
                        wbank_n      = ~wbank;
                        waddr_n      = '0;
                    end
                end
                default: ;
            endcase
        end
        if (rel) bst_n[rbank] = IDLE;
    end

    always_ff @(posedge iclk) begin
        if (iclkena && we) mem[{wbank, wa}] <= idat;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            bst    <= '{IDLE, IDLE};
            len    <= '{default: '0};
            wbank  <= 1'b0;
            waddr  <= '0;
            oerr   <= 1'b0;
            obusy  <= 1'b0;
            ibank  <= 1'b0;
            iaddr  <= '0;
            issued <= '0;
            rbank  <= 1'b0;
            fdat   <= '{default: '0};
            fsof   <= '0;
            feof   <= '0;
            fwp    <= 1'b0;
            frp    <= 1'b0;
            fcnt   <= '0;
        end else if (iclkena) begin
            bst   <= bst_n;
            len   <= len_n;
            wbank <= wbank_n;
            waddr <= waddr_n;
            oerr  <= err_n;
            obusy <= (bst_n[wbank_n] == FULL);
            if (issue) begin
                fdat[fwp] <= mem[{ibank, iaddr[pADDR_W-1:0]}];
                fsof[fwp] <= (iaddr == '0);
                feof[fwp] <= last;
                fwp       <= ~fwp;
                if (last) begin
                    iaddr          <= '0;
                    ibank          <= ~ibank;
                    issued[ibank]  <= 1'b1;
                end else begin
                    iaddr <= iaddr + ONE;
                end
            end
            if (pop) begin
                frp <= ~frp;
                if (feof[frp]) begin
                    rbank         <= ~rbank;
                    issued[rbank] <= 1'b0;
                end
            end
            fcnt <= fcnt + {1'b0, issue} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_ldpc_3gpp_enc_p1_obuf.sv
// Directed self-checking bench for the p1 ping-pong output buffer.
// A second instance with a 4-word bank covers the overflow boundary.
module tb_ldpc_3gpp_enc_p1_obuf;
    logic       iclk = 1'b0;
    logic       ireset, iclkena;
    logic       ival, isof, ieof, iready;
    logic [7:0] idat;
    logic       obusy, oerr, oval, osof, oeof;
    logic [7:0] odat;
    logic       ival2, isof2, ieof2, iready2;
    logic [7:0] idat2;
    logic       obusy2, oerr2, oval2, osof2, oeof2;
    logic [7:0] odat2;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] q[$];

    always #5 iclk = ~iclk;

    ldpc_3gpp_enc_p1_obuf #(.pADDR_W(8), .pDAT_W(8)) u_dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ival(ival), .isof(isof), .ieof(ieof), .idat(idat),
        .obusy(obusy), .oerr(oerr), .oval(oval), .iready(iready),
        .osof(osof), .oeof(oeof), .odat(odat)
    );

    ldpc_3gpp_enc_p1_obuf #(.pADDR_W(2), .pDAT_W(8)) u_small (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ival(ival2), .isof(isof2), .ieof(ieof2), .idat(idat2),
        .obusy(obusy2), .oerr(oerr2), .oval(oval2), .iready(iready2),
        .osof(osof2), .oeof(oeof2), .odat(odat2)
    );

    // accepted words, taken away from the active edge
    always @(negedge iclk)
        if (!ireset && iclkena && oval && iready)
            q.push_back({osof, oeof, odat});

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    task automatic drv(input logic v, input logic s, input logic e,
                       input logic [7:0] d);
        ival = v; isof = s; ieof = e; idat = d;
    endtask

    task automatic wr_frame(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            drv(1'b1, i == 0, i == n - 1, base + 8'(i));
            tick();
        end
        drv(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        logic [9:0] got;
        ireset = 1'b1; iclkena = 1'b1; iready = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        ival2 = 0; isof2 = 0; ieof2 = 0; idat2 = 0; iready2 = 0;
        tick(); tick();
        n_cmp++;
        if ({oval, osof, oeof, obusy, oerr, odat} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_init outs=%h want 0",
                     {oval, osof, oeof, obusy, oerr, odat});
        end
        ireset = 1'b0;
        wr_frame(8'hE1, 2);
        drv(1'b1, 1'b1, 1'b0, 8'hF1);
        tick();
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ({oval, odat} !== {1'b1, 8'hE1}) begin
            n_err++;
            $display("FAIL reset_pre oval/odat=%h want 1e1", {oval, odat});
        end
        ireset = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({oval, osof, oeof, obusy, oerr, odat} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_mid outs=%h want 0",
                     {oval, osof, oeof, obusy, oerr, odat});
        end
        ireset = 1'b0;
        q.delete();
        iready = 1'b1;
        wr_frame(8'h01, 4);
        repeat (6) tick();
        n_cmp++;
        if (q.size() != 4) begin
            n_err++;
            $display("FAIL reset_cnt words=%0d want 4", q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < q.size()) ? q[i] : 10'h3FF;
            n_cmp++;
            if (got !== {i == 0, i == 3, 8'h01 + 8'(i)}) begin
                n_err++;
                $display("FAIL reset_word%0d got=%h want %h", i, got,
                         {i == 0, i == 3, 8'h01 + 8'(i)});
            end
        end
    endtask

    task automatic test_single;
        iready = 1'b1;
        wr_frame(8'h11, 5);
        n_cmp++;
        if (oval !== 1'b0) begin
            n_err++;
            $display("FAIL single_early oval=%b want 0", oval);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({oval, osof, oeof, odat} !== {1'b1, i == 0, i == 4, 8'h11 + 8'(i)}) begin
                n_err++;
                $display("FAIL single_w%0d got=%h want %h", i,
                         {oval, osof, oeof, odat},
                         {1'b1, i == 0, i == 4, 8'h11 + 8'(i)});
            end
            tick();
        end
        n_cmp++;
        if (oval !== 1'b0) begin
            n_err++;
            $display("FAIL single_end oval=%b want 0", oval);
        end
    endtask

    task automatic test_pingpong;
        int ec;
        logic [7:0] e;
        iready = 1'b0;
        wr_frame(8'h21, 3);
        wr_frame(8'h31, 3);
        n_cmp++;
        if (obusy !== 1'b1) begin
            n_err++;
            $display("FAIL pp_busy obusy=%b want 1", obusy);
        end
        ec = 0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, i == 0, i == 2, 8'h41 + 8'(i));
            tick();
            if (oerr === 1'b1) ec++;
        end
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        n_cmp++;
        if (ec != 3 || oerr !== 1'b0) begin
            n_err++;
            $display("FAIL pp_oerr pulses=%0d last=%b want 3/0", ec, oerr);
        end
        n_cmp++;
        if ({oval, odat} !== {1'b1, 8'h21}) begin
            n_err++;
            $display("FAIL pp_hold got=%h want 121", {oval, odat});
        end
        iready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = (i < 3) ? 8'h21 + 8'(i) : 8'h31 + 8'(i - 3);
            n_cmp++;
            if ({oval, odat} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL pp_w%0d got=%h want %h", i, {oval, odat}, {1'b1, e});
            end
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (obusy !== (i == 2)) begin
                    n_err++;
                    $display("FAIL pp_busy%0d obusy=%b want %b", i, obusy, i == 2);
                end
            end
            tick();
        end
        n_cmp++;
        if (oval !== 1'b0) begin
            n_err++;
            $display("FAIL pp_end oval=%b want 0", oval);
        end
    endtask

    task automatic test_backpressure;
        logic pv;
        logic [7:0] pd;
        logic [9:0] got;
        iready = 1'b0;
        wr_frame(8'h51, 8);
        tick();
        q.delete();
        for (int c = 0; c < 24; c++) begin
            pv = oval; pd = odat;
            iready = (c % 2 == 0);
            tick();
            if (c % 2 == 1 && pv) begin
                n_cmp++;
                if ({oval, odat} !== {1'b1, pd}) begin
                    n_err++;
                    $display("FAIL bp_hold%0d got=%h want %h", c, {oval, odat}, {1'b1, pd});
                end
            end
        end
        n_cmp++;
        if (q.size() != 8) begin
            n_err++;
            $display("FAIL bp_cnt words=%0d want 8", q.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < q.size()) ? q[i] : 10'h3FF;
            n_cmp++;
            if (got !== {i == 0, i == 7, 8'h51 + 8'(i)}) begin
                n_err++;
                $display("FAIL bp_word%0d got=%h want %h", i, got,
                         {i == 0, i == 7, 8'h51 + 8'(i)});
            end
        end
    endtask

    task automatic test_one_word;
        iready = 1'b1;
        drv(1'b1, 1'b1, 1'b1, 8'h66);
        tick();
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        n_cmp++;
        if ({oval, osof, oeof, odat} !== {3'b111, 8'h66}) begin
            n_err++;
            $display("FAIL one_word got=%h want 766", {oval, osof, oeof, odat});
        end
        tick();
        n_cmp++;
        if (oval !== 1'b0) begin
            n_err++;
            $display("FAIL one_end oval=%b want 0", oval);
        end
    endtask

    task automatic test_overflow;
        int ec;
        iready2 = 1'b0;
        ec = 0;
        for (int i = 0; i < 6; i++) begin
            ival2 = 1'b1; isof2 = (i == 0); ieof2 = (i == 5);
            idat2 = 8'h71 + 8'(i);
            tick();
            if (oerr2 === 1'b1) ec++;
        end
        ival2 = 0; isof2 = 0; ieof2 = 0; idat2 = 0;
        tick();
        n_cmp++;
        if (ec != 2) begin
            n_err++;
            $display("FAIL ovf_oerr pulses=%0d want 2", ec);
        end
        iready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({oval2, osof2, oeof2, odat2} !== {1'b1, i == 0, i == 3, 8'h71 + 8'(i)}) begin
                n_err++;
                $display("FAIL ovf_w%0d got=%h want %h", i,
                         {oval2, osof2, oeof2, odat2},
                         {1'b1, i == 0, i == 3, 8'h71 + 8'(i)});
            end
            tick();
        end
        n_cmp++;
        if (oval2 !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_end oval=%b want 0", oval2);
        end
    endtask

    task automatic test_restart;
        logic [7:0] d [6];
        logic [9:0] got;
        d = '{8'h81, 8'h82, 8'h91, 8'h92, 8'h93, 8'h94};
        iready = 1'b1;
        q.delete();
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, i == 0 || i == 2, i == 5, d[i]);
            tick();
        end
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (6) tick();
        n_cmp++;
        if (q.size() != 4) begin
            n_err++;
            $display("FAIL rst_cnt words=%0d want 4", q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < q.size()) ? q[i] : 10'h3FF;
            n_cmp++;
            if (got !== {i == 0, i == 3, 8'h91 + 8'(i)}) begin
                n_err++;
                $display("FAIL rst_word%0d got=%h want %h", i, got,
                         {i == 0, i == 3, 8'h91 + 8'(i)});
            end
        end
    endtask

    task automatic test_clkena;
        logic [9:0] got;
        iready = 1'b0;
        wr_frame(8'hA1, 6);
        tick();
        q.delete();
        iready = 1'b1;
        tick(); tick();
        iclkena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({oval, odat} !== {1'b1, 8'hA3}) begin
                n_err++;
                $display("FAIL ce_hold%0d got=%h want 1a3", i, {oval, odat});
            end
        end
        iclkena = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if (q.size() != 6) begin
            n_err++;
            $display("FAIL ce_cnt words=%0d want 6", q.size());
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < q.size()) ? q[i] : 10'h3FF;
            n_cmp++;
            if (got !== {i == 0, i == 5, 8'hA1 + 8'(i)}) begin
                n_err++;
                $display("FAIL ce_word%0d got=%h want %h", i, got,
                         {i == 0, i == 5, 8'hA1 + 8'(i)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pingpong();
        test_backpressure();
        test_one_word();
        test_overflow();
        test_restart();
        test_clkena();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
